// File: rtl/butterfly_r2_cfg_pkg.sv
// Shared constants and arithmetic helpers for the radix-2 butterfly datapath.
// All helpers work on one wide signed accumulator type so callers only size-cast at the edges.
package butterfly_pkg;

    localparam logic MODE_DIF = 1'b0;
    localparam logic MODE_DIT = 1'b1;
    localparam int   LATENCY  = 4;
    localparam int   ACC_W    = 96;

    typedef logic signed [ACC_W-1:0] acc_t;

    typedef struct packed {
        logic hit;
        acc_t val;
    } sat_t;

    // Round half up, then arithmetic shift right by sh (sh >= 1).
    function automatic acc_t round_shift(input acc_t v, input int sh);
        return (v + (acc_t'(1) <<< (sh - 1))) >>> sh;
    endfunction

    function automatic acc_t half_up(input acc_t v);
        return (v + acc_t'(1)) >>> 1;
    endfunction

    // Clamp to the signed range of a dw-bit value and report whether clamping happened.
    function automatic sat_t sat(input acc_t v, input int dw);
        acc_t hi;
        acc_t lo;
        sat_t r;
        hi    = (acc_t'(1) <<< (dw - 1)) - acc_t'(1);
        lo    = -hi - acc_t'(1);
        r.hit = (v > hi) || (v < lo);
        r.val = (v > hi) ? hi : ((v < lo) ? lo : v);
        return r;
    endfunction

endpackage

// File: rtl/butterfly_r2_cfg_cmult_shared.sv
// Complex multiplier on two shared multipliers: real part in the start cycle,
// imaginary part in the following cycle; y and w must be held across both cycles.
module cmult_shared
    import butterfly_pkg::*;
#(
    parameter int YW        = 33,
    parameter int FW        = 16,
    parameter int FRAC_BITS = 14,
    parameter int PW        = YW + FW + 1 - FRAC_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic signed [YW-1:0] y_re,
    input  logic signed [YW-1:0] y_im,
    input  logic signed [FW-1:0] w_re,
    input  logic signed [FW-1:0] w_im,
    output logic signed [PW-1:0] p_re,
    output logic signed [PW-1:0] p_im
);

    logic                    cyc_b;
    logic signed [FW-1:0]    opw0;
    logic signed [FW-1:0]    opw1;
    logic signed [YW+FW-1:0] prod0;
    logic signed [YW+FW-1:0] prod1;
    acc_t                    sum;
    acc_t                    rnd;

    // Swapping the twiddle operands turns the real-part products into the imaginary-part ones.
    always_comb begin
        opw0  = cyc_b ? w_im : w_re;
        opw1  = cyc_b ? w_re : w_im;
        prod0 = (YW+FW)'(y_re) * (YW+FW)'(opw0);
        prod1 = (YW+FW)'(y_im) * (YW+FW)'(opw1);
        sum   = cyc_b ? (acc_t'(prod0) + acc_t'(prod1)) : (acc_t'(prod0) - acc_t'(prod1));
        rnd   = round_shift(sum, FRAC_BITS);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_b <= 1'b0;
            p_re  <= '0;
            p_im  <= '0;
        end else begin
            cyc_b <= start;
            if (start) p_re <= PW'(rnd);
            if (cyc_b) p_im <= PW'(rnd);
        end
    end

endmodule

// File: rtl/butterfly_r2_cfg.sv
// Radix-2 DIF/DIT butterfly, one transfer every two cycles, fixed four-edge latency.
// Handshake: a transfer happens on a rising edge where in_valid && in_ready; no output backpressure.
module butterfly_r2_cfg
    import butterfly_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int FACTOR_WIDTH = 16,
    parameter int FRAC_BITS    = 14
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      mode,
    input  logic                      scale,
    input  logic [2*DATA_WIDTH-1:0]   in_x0,
    input  logic [2*DATA_WIDTH-1:0]   in_x1,
    input  logic [2*FACTOR_WIDTH-1:0] w,
    output logic                      out_valid,
    output logic [2*DATA_WIDTH-1:0]   out_x0,
    output logic [2*DATA_WIDTH-1:0]   out_x1,
    output logic                      ovf,
    input  logic                      ovf_clr
);

    localparam int DW = DATA_WIDTH;
    localparam int FW = FACTOR_WIDTH;
    localparam int YW = DW + 1;
    localparam int PW = YW + FW + 1 - FRAC_BITS;

    logic                 phase;
    logic                 accept;
    logic                 s0_v, s1_v, s2_v, s3_v;
    logic signed [DW-1:0] x0r_q, x0i_q, x1r_q, x1i_q;
    logic signed [FW-1:0] wr_q, wi_q;
    logic                 mode_q, scale_q;
    logic signed [DW-1:0] x0r_2, x0i_2, x1r_2, x1i_2;
    logic                 mode_2, scale_2;
    logic signed [YW-1:0] y_re, y_im;
    logic signed [PW-1:0] p_re, p_im;
    acc_t                 a0r, a0i, a1r, a1i;
    sat_t                 q0r, q0i, q1r, q1i;
    logic [DW-1:0]        r0r, r0i, r1r, r1i;
    logic                 hit_3;

    assign in_ready = ~rst & ~phase;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase   <= 1'b0;
            s0_v    <= 1'b0;
            s1_v    <= 1'b0;
            s2_v    <= 1'b0;
            x0r_q   <= '0; x0i_q <= '0; x1r_q <= '0; x1i_q <= '0;
            wr_q    <= '0; wi_q  <= '0;
            mode_q  <= 1'b0;
            scale_q <= 1'b0;
            x0r_2   <= '0; x0i_2 <= '0; x1r_2 <= '0; x1i_2 <= '0;
            mode_2  <= 1'b0;
            scale_2 <= 1'b0;
        end else begin
            phase <= accept;
            s0_v  <= accept;
            s1_v  <= s0_v;
            s2_v  <= s1_v;
            if (accept) begin
                x0r_q   <= in_x0[2*DW-1:DW];
                x0i_q   <= in_x0[DW-1:0];
                x1r_q   <= in_x1[2*DW-1:DW];
                x1i_q   <= in_x1[DW-1:0];
                wr_q    <= w[2*FW-1:FW];
                wi_q    <= w[FW-1:0];
                mode_q  <= mode;
                scale_q <= scale;
            end
            // Snapshot before the next accept (same edge) overwrites the input registers.
            if (s1_v) begin
                x0r_2   <= x0r_q; x0i_2 <= x0i_q;
                x1r_2   <= x1r_q; x1i_2 <= x1i_q;
                mode_2  <= mode_q;
                scale_2 <= scale_q;
            end
        end
    end

    // DIF multiplies the difference (one extra bit, no wrap); DIT multiplies x1 itself.
    always_comb begin
        if (mode_q == MODE_DIT) begin
            y_re = YW'(x1r_q);
            y_im = YW'(x1i_q);
        end else begin
            y_re = YW'(x0r_q) - YW'(x1r_q);
            y_im = YW'(x0i_q) - YW'(x1i_q);
        end
    end

    cmult_shared #(
        .YW        (YW),
        .FW        (FW),
        .FRAC_BITS (FRAC_BITS),
        .PW        (PW)
    ) u_cmult (
        .clk   (clk),
        .rst   (rst),
        .start (s0_v),
        .y_re  (y_re),
        .y_im  (y_im),
        .w_re  (wr_q),
        .w_im  (wi_q),
        .p_re  (p_re),
        .p_im  (p_im)
    );

    always_comb begin
        if (mode_2 == MODE_DIT) begin
            a0r = acc_t'(x0r_2) + acc_t'(p_re);
            a0i = acc_t'(x0i_2) + acc_t'(p_im);
            a1r = acc_t'(x0r_2) - acc_t'(p_re);
            a1i = acc_t'(x0i_2) - acc_t'(p_im);
        end else begin
            a0r = acc_t'(x0r_2) + acc_t'(x1r_2);
            a0i = acc_t'(x0i_2) + acc_t'(x1i_2);
            a1r = acc_t'(p_re);
            a1i = acc_t'(p_im);
        end
        if (scale_2) begin
            a0r = half_up(a0r);
            a0i = half_up(a0i);
            a1r = half_up(a1r);
            a1i = half_up(a1i);
        end
        q0r = sat(a0r, DW);
        q0i = sat(a0i, DW);
        q1r = sat(a1r, DW);
        q1i = sat(a1i, DW);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_v      <= 1'b0;
            hit_3     <= 1'b0;
            r0r <= '0; r0i <= '0; r1r <= '0; r1i <= '0;
            out_valid <= 1'b0;
            out_x0    <= '0;
            out_x1    <= '0;
            ovf       <= 1'b0;
        end else begin
            s3_v  <= s2_v;
            hit_3 <= q0r.hit | q0i.hit | q1r.hit | q1i.hit;
            r0r   <= DW'(q0r.val);
            r0i   <= DW'(q0i.val);
            r1r   <= DW'(q1r.val);
            r1i   <= DW'(q1i.val);
            out_valid <= s3_v;
            if (s3_v) begin
                out_x0 <= {r0r, r0i};
                out_x1 <= {r1r, r1i};
            end
            // A fresh saturation outranks a simultaneous clear.
            if (s3_v && hit_3) ovf <= 1'b1;
            else if (ovf_clr)  ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_butterfly_r2_cfg.sv
// Directed-vector bench for butterfly_r2_cfg: table of hand-computed results plus
// sequences for sticky overflow, back-to-back transfers and asynchronous reset.
module tb_butterfly_r2_cfg;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        mode;
  logic        scale;
  logic [63:0] in_x0;
  logic [63:0] in_x1;
  logic [31:0] w;
  logic        out_valid;
  logic [63:0] out_x0;
  logic [63:0] out_x1;
  logic        ovf;
  logic        ovf_clr;

  typedef struct {
    logic              mode;
    logic              scale;
    logic signed [31:0] x0r, x0i, x1r, x1i;
    logic signed [15:0] wr, wi;
    logic signed [31:0] e0r, e0i, e1r, e1i;
    logic              eovf;
  } vec_t;

  logic [127:0] exp_q[$];
  int           acc_q[$];
  int           cyc = 0;
  int           n_cmp = 0;
  int           n_fail = 0;
  int           n_out = 0;
  logic         ovf_at_out = 1'b0;
  vec_t         tbl[9];
  vec_t         b2b[4];
  vec_t         satv;
  vec_t         satv_s;

  butterfly_r2_cfg dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .scale     (scale),
    .in_x0     (in_x0),
    .in_x1     (in_x1),
    .w         (w),
    .out_valid (out_valid),
    .out_x0    (out_x0),
    .out_x1    (out_x1),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t mk(input logic md, input logic sc,
                              input logic signed [31:0] x0r, input logic signed [31:0] x0i,
                              input logic signed [31:0] x1r, input logic signed [31:0] x1i,
                              input logic signed [15:0] wr, input logic signed [15:0] wi,
                              input logic signed [31:0] e0r, input logic signed [31:0] e0i,
                              input logic signed [31:0] e1r, input logic signed [31:0] e1i,
                              input logic eovf);
    vec_t v;
    v.mode = md; v.scale = sc;
    v.x0r = x0r; v.x0i = x0i; v.x1r = x1r; v.x1i = x1i;
    v.wr = wr; v.wi = wi;
    v.e0r = e0r; v.e0i = e0i; v.e1r = e1r; v.e1i = e1i;
    v.eovf = eovf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic drive(input vec_t v);
    mode  = v.mode;
    scale = v.scale;
    in_x0 = {v.x0r, v.x0i};
    in_x1 = {v.x1r, v.x1i};
    w     = {v.wr, v.wi};
  endtask

  task automatic send(input vec_t v);
    bit done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      drive(v);
      in_valid = 1'b1;
      if (in_ready) begin
        @(posedge clk);
        #1;
        acc_q.push_back(cyc);
        exp_q.push_back({v.e0r, v.e0i, v.e1r, v.e1i});
        done = 1;
      end
    end
    in_valid = 1'b0;
    chk("accept_timeout", 128'(done), 128'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    chk("drain_timeout", 128'(exp_q.size()), 128'd0);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
  endtask

  // scoreboard
  initial begin
    logic [127:0] e;
    int           a;
    forever begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        n_out++;
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", 128'(out_valid), 128'd0);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          chk("out_x0_x1", {out_x0, out_x1}, e);
          chk("latency", 128'(cyc - a), 128'd4);
          ovf_at_out = ovf;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int n0;
    logic rdy;

    tbl[0] = mk(0, 0, 100, 50, 20, 10, 16384, 0, 120, 60, 80, 40, 0);
    tbl[1] = mk(1, 0, 100, 0, 0, 40, 0, -16384, 140, 0, 60, 0, 0);
    tbl[2] = mk(0, 0, 3, 0, 0, 0, 8192, 0, 3, 0, 2, 0, 0);
    tbl[3] = mk(0, 0, -3, 0, 0, 0, 8192, 0, -3, 0, -1, 0, 0);
    tbl[4] = mk(1, 1, -7, 5, 3, -2, 0, 16384, -2, 4, -4, 1, 0);
    tbl[5] = mk(0, 0, 10, 0, 0, 0, 16'sh8000, 0, 10, 0, -20, 0, 0);
    tbl[6] = mk(0, 0, 1000, -200, -500, 300, 11585, -11585, 500, 100, 707, -1414, 0);
    tbl[7] = mk(0, 0, 32'sh80000000, 0, 1, 0, 16384, 0, 32'sh80000001, 0, 32'sh80000000, 0, 1);
    tbl[8] = mk(1, 0, 0, 32'sh7fffffff, 0, 5, 16384, 0, 0, 32'sh7fffffff, 0, 32'sh7ffffffa, 1);

    b2b[0] = mk(0, 1, 100, 50, 20, 10, 16384, 0, 60, 30, 40, 20, 0);
    b2b[1] = tbl[1];
    b2b[2] = tbl[4];
    b2b[3] = tbl[2];

    satv   = mk(0, 0, 32'sh7fffffff, 0, 1, 0, 16384, 0, 32'sh7fffffff, 0, 32'sh7ffffffe, 0, 1);
    satv_s = mk(0, 1, 32'sh7fffffff, 0, 1, 0, 16384, 0, 32'sh40000000, 0, 32'sh3fffffff, 0, 0);

    rst = 1'b1; in_valid = 1'b0; mode = 1'b0; scale = 1'b0;
    in_x0 = '0; in_x1 = '0; w = '0; ovf_clr = 1'b0;

    // reset state
    #12;
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_outs", {out_x0, out_x1}, 128'd0);
    chk("rst_ovf", 128'(ovf), 128'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 128'(in_ready), 128'd1);

    // table-driven vectors, ovf cleared between them
    for (int i = 0; i < 9; i++) begin
      send(tbl[i]);
      drain();
      chk("ovf_vec", 128'(ovf_at_out), 128'(tbl[i].eovf));
      pulse_clr();
    end

    // sticky overflow, scaled repeat, clear, and set-beats-clear
    send(satv);
    drain();
    chk("ovf_set", 128'(ovf), 128'd1);
    send(satv_s);
    drain();
    chk("ovf_sticky", 128'(ovf), 128'd1);
    pulse_clr();
    #1;
    chk("ovf_cleared", 128'(ovf), 128'd0);
    @(negedge clk);
    ovf_clr = 1'b1;
    send(satv);
    drain();
    chk("ovf_set_wins", 128'(ovf_at_out), 128'd1);
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("ovf_clr_after", 128'(ovf), 128'd0);
    send(satv);
    drain();

    // in_valid held for 8 cycles: accepts on alternate cycles
    k = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("in_ready_seq", 128'(in_ready), 128'((i % 2) == 0));
      drive(b2b[(k < 4) ? k : 3]);
      in_valid = 1'b1;
      rdy = in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        acc_q.push_back(cyc);
        exp_q.push_back({b2b[k].e0r, b2b[k].e0i, b2b[k].e1r, b2b[k].e1i});
        k++;
      end
    end
    in_valid = 1'b0;
    chk("b2b_accepts", 128'(k), 128'd4);
    drain();

    // asynchronous reset with two butterflies in flight
    send(tbl[6]);
    send(tbl[1]);
    @(posedge clk);
    #3;
    rst = 1'b1;
    exp_q.delete();
    acc_q.delete();
    #1;
    chk("arst_out_valid", 128'(out_valid), 128'd0);
    chk("arst_outs", {out_x0, out_x1}, 128'd0);
    chk("arst_ovf", 128'(ovf), 128'd0);
    chk("arst_in_ready", 128'(in_ready), 128'd0);
    n0 = n_out;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_ready_release", 128'(in_ready), 128'd1);
    repeat (10) @(posedge clk);
    #2;
    chk("no_out_after_rst", 128'(n_out - n0), 128'd0);
    send(tbl[0]);
    drain();
    chk("ovf_after_rst", 128'(ovf), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
